wb_sdram_port_arbiter: RTL and testbench
========================================

Name: wb_sdram_port_arbiter

Overview:
- Shares the single internal Wishbone command port of the SDRAM controller between WB_PORTS Wishbone masters, such as CPU instruction, CPU data and DMA.
- Round-robin arbitration; a grant is held for the full Wishbone cycle (cyc high), so bursts stay atomic.
- Sits between the flattened per-port Wishbone bus (packed vectors, port i at slice [i*W +: W]) and the controller's buffer/bank logic.
- Fully synchronous to wb_clk.

Parameters:
- WB_PORTS, 3, number of requesting masters (1..8).
- AW, 32, address width per port.
- DW, 32, data width per port.

Ports:
- wb_clk  in  1  Wishbone clock.
- wb_rst_n  in  1  reset, asynchronous assert, active-low.
- wb_adr_i  in  WB_PORTS*AW  packed master addresses.
- wb_dat_i  in  WB_PORTS*DW  packed write data.
- wb_sel_i  in  WB_PORTS*DW/8  packed byte selects.
- wb_we_i  in  WB_PORTS  write enables.
- wb_cyc_i  in  WB_PORTS  cycle requests.
- wb_stb_i  in  WB_PORTS  strobes.
- wb_cti_i  in  WB_PORTS*3  cycle type.
- wb_bte_i  in  WB_PORTS*2  burst type.
- wb_dat_o  out  WB_PORTS*DW  read data (m_dat_i broadcast to every slice).
- wb_ack_o  out  WB_PORTS  acks (granted port only).
- m_adr_o, m_dat_o, m_sel_o, m_we_o, m_cyc_o, m_stb_o, m_cti_o, m_bte_o  out  AW/DW/DW/8/1/1/1/3/2  muxed bus to the controller.
- m_dat_i  in  DW  controller read data.
- m_ack_i  in  1  controller ack.
- grant_o  out  WB_PORTS  one-hot current grant (debug/perf).
- busy_o  out  1  high whenever a grant is held.

Behaviour:
- Reset (wb_rst_n low, async): state=IDLE, grant_o=0, busy_o=0, rr_ptr=0. All m_* outputs are 0. wb_ack_o=0.
- State IDLE:
  - Picks the first port with wb_cyc_i high, searching from rr_ptr upward modulo WB_PORTS.
  - Grant is registered; m_* outputs follow it on the next cycle. Request-to-m_cyc_o latency is exactly 1 cycle.
  - If no cyc is high, stays in IDLE.
- State GRANT:
  - m_* = slice[g] of the inputs, combinational from the registered grant index g.
  - m_cyc_o = wb_cyc_i[g]; m_stb_o = wb_stb_i[g].
  - wb_ack_o[g] = m_ack_i; all other acks are 0.
  - Leaves GRANT when wb_cyc_i[g] goes low (sampled at the clock edge) and enters RELEASE.
  - rr_ptr <= (g+1) mod WB_PORTS.
- State RELEASE:
  - One dead cycle with m_cyc_o=0 and m_stb_o=0, so the controller sees a cyc gap between masters.
  - Then returns to IDLE and evaluates requests in that same cycle. Back-to-back handoff costs 2 cycles: GRANT, then RELEASE, then IDLE sampling, then the new GRANT.
- Burst rules:
  - cti/bte are passed through unmodified.
  - A master dropping cyc mid-burst (before cti=3'b111) still releases the grant.
  - The controller is responsible for flushing its own buffer.
  - m_ack_i arriving while not in GRANT is discarded; no port is acked.
- Single-requester case:
  - A port that re-asserts cyc immediately is re-granted after RELEASE.
  - rr_ptr wraps, so with WB_PORTS=1 the same port is always granted.
- Simultaneous events: cyc of other ports rising during GRANT is ignored until IDLE. No pre-emption.
- Reset mid-transaction: outputs clear immediately (async) and the grant is lost. Masters must restart.
- Widths: the grant index is $clog2(WB_PORTS) bits, minimum 1. rr_ptr increment wraps explicitly at WB_PORTS-1, not at a power of 2.

Optional Feature:
- Macro WB_ARB_PORT0_PRIO_EN.
- Defined: in IDLE, port 0 wins whenever wb_cyc_i[0] is high, regardless of rr_ptr. The remaining ports are round-robin among themselves. rr_ptr advances only on grants to ports 1..WB_PORTS-1.
- Undefined: pure round-robin as above.

Decomposition:
- Package wb_sdram_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_GRANT=2'd1, ST_RELEASE=2'd2.
  - CTI_EOB=3'b111 and CTI_CLASSIC=3'b000.
  - the function computing the index width.
- One natural sub-module, wb_sdram_rr_pick: combinational round-robin priority encoder.
  - Inputs: request vector, rr_ptr.
  - Outputs: index and valid.
  - Shared with future bank schedulers.

Test Plan:
- Reset:
  - Stimulus: hold wb_rst_n=0 with cyc[2:0]=3'b111.
  - Required: grant_o=0, m_cyc_o=0, wb_ack_o=0. One cycle after release, grant_o=3'b001.
- Round-robin fairness:
  - Stimulus: all 3 ports issue continuous 8-beat bursts (cti 010...111), 30 bursts total.
  - Required: grant order 0,1,2,0,1,2...; each port gets exactly 10 bursts; 2-cycle gap between bursts.
- Ack routing:
  - Stimulus: port 1 single read of address 0x1000 while ports 0 and 2 idle; controller returns m_dat_i=0xDEADBEEF with m_ack_i.
  - Required: only wb_ack_o[1]=1; wb_dat_o slice 1 = 0xDEADBEEF.
- Mid-burst abort:
  - Stimulus: port 2 drops cyc after 3 acks of an 8-beat burst while port 0 is requesting.
  - Required: RELEASE, then port 0 granted 2 cycles later; no ack reaches port 2 afterwards.
- Stray ack:
  - Stimulus: pulse m_ack_i during RELEASE and during IDLE.
  - Required: wb_ack_o stays 0.
- Priority macro:
  - Stimulus: with WB_ARB_PORT0_PRIO_EN defined, ports 0, 1 and 2 all requesting.
  - Required: port 0 is granted on every IDLE evaluation; ports 1 and 2 alternate only when port 0 is idle.

Source files
------------

// File: rtl/wb_sdram_arb_pkg.sv
// wb_sdram_arb_pkg: shared FSM encoding, Wishbone cycle-type constants and index-width helper
// for the SDRAM port arbiter.
package wb_sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;

    // A single port still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_sdram_rr_pick.sv
// wb_sdram_rr_pick: combinational round-robin priority encoder; returns the first
// requester at or above ptr, wrapping modulo N.
module wb_sdram_rr_pick
    import wb_sdram_arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Walk distances from farthest to nearest so the nearest requester is written last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int k = N - 1; k >= 0; k--)
            for (int j = 0; j < N; j++)
                if (req[j] && (int'(ptr) + k == j || int'(ptr) + k == j + N)) begin
                    idx   = IW'(j);
                    valid = 1'b1;
                end
    end

endmodule

// File: rtl/wb_sdram_port_arbiter.sv
// wb_sdram_port_arbiter: round-robin arbiter sharing the SDRAM controller Wishbone port.
// Define WB_ARB_PORT0_PRIO_EN to give port 0 absolute priority over the round-robin ports.
module wb_sdram_port_arbiter
    import wb_sdram_arb_pkg::*;
#(
    parameter int WB_PORTS = 3,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic                       wb_clk,
    input  logic                       wb_rst_n,
    input  logic [WB_PORTS*AW-1:0]     wb_adr_i,
    input  logic [WB_PORTS*DW-1:0]     wb_dat_i,
    input  logic [WB_PORTS*DW/8-1:0]   wb_sel_i,
    input  logic [WB_PORTS-1:0]        wb_we_i,
    input  logic [WB_PORTS-1:0]        wb_cyc_i,
    input  logic [WB_PORTS-1:0]        wb_stb_i,
    input  logic [WB_PORTS*3-1:0]      wb_cti_i,
    input  logic [WB_PORTS*2-1:0]      wb_bte_i,
    output logic [WB_PORTS*DW-1:0]     wb_dat_o,
    output logic [WB_PORTS-1:0]        wb_ack_o,
    output logic [AW-1:0]              m_adr_o,
    output logic [DW-1:0]              m_dat_o,
    output logic [DW/8-1:0]            m_sel_o,
    output logic                       m_we_o,
    output logic                       m_cyc_o,
    output logic                       m_stb_o,
    output logic [2:0]                 m_cti_o,
    output logic [1:0]                 m_bte_o,
    input  logic [DW-1:0]              m_dat_i,
    input  logic                       m_ack_i,
    output logic [WB_PORTS-1:0]        grant_o,
    output logic                       busy_o
);

    localparam int IW = idx_w(WB_PORTS);

    state_t               state;
    logic [IW-1:0]        g;
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        rr_idx;
    logic [IW-1:0]        pick_idx;
    logic                 rr_valid;
    logic                 pick_valid;
    logic                 adv;
    logic [WB_PORTS-1:0]  rr_req;

`ifdef WB_ARB_PORT0_PRIO_EN
    assign rr_req     = wb_cyc_i & ~WB_PORTS'(1);
    assign pick_idx   = wb_cyc_i[0] ? '0 : rr_idx;
    assign pick_valid = wb_cyc_i[0] | rr_valid;
    assign adv        = g != '0;
`else
    assign rr_req     = wb_cyc_i;
    assign pick_idx   = rr_idx;
    assign pick_valid = rr_valid;
    assign adv        = 1'b1;
`endif

    wb_sdram_rr_pick #(.N(WB_PORTS), .IW(IW)) u_pick (
        .req   (rr_req),
        .ptr   (rr_ptr),
        .idx   (rr_idx),
        .valid (rr_valid)
    );

    assign wb_dat_o = {WB_PORTS{m_dat_i}};

    // Outside GRANT every controller-side output is forced low, including during RELEASE.
    always_comb begin
        m_adr_o  = '0;
        m_dat_o  = '0;
        m_sel_o  = '0;
        m_we_o   = 1'b0;
        m_cyc_o  = 1'b0;
        m_stb_o  = 1'b0;
        m_cti_o  = '0;
        m_bte_o  = '0;
        wb_ack_o = '0;
        for (int i = 0; i < WB_PORTS; i++)
            if (state == ST_GRANT && g == IW'(i)) begin
                m_adr_o     = wb_adr_i[i*AW +: AW];
                m_dat_o     = wb_dat_i[i*DW +: DW];
                m_sel_o     = wb_sel_i[i*(DW/8) +: DW/8];
                m_we_o      = wb_we_i[i];
                m_cyc_o     = wb_cyc_i[i];
                m_stb_o     = wb_stb_i[i];
                m_cti_o     = wb_cti_i[i*3 +: 3];
                m_bte_o     = wb_bte_i[i*2 +: 2];
                wb_ack_o[i] = m_ack_i;
            end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state   <= ST_IDLE;
            g       <= '0;
            rr_ptr  <= '0;
            grant_o <= '0;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:
                    if (pick_valid) begin
                        state   <= ST_GRANT;
                        g       <= pick_idx;
                        grant_o <= WB_PORTS'(1) << pick_idx;
                        busy_o  <= 1'b1;
                    end
                ST_GRANT:
                    if (!m_cyc_o) begin
                        state   <= ST_RELEASE;
                        grant_o <= '0;
                        busy_o  <= 1'b0;
                        if (adv)
                            rr_ptr <= (g == IW'(WB_PORTS - 1)) ? '0 : g + IW'(1);
                    end
                ST_RELEASE:
                    state <= ST_IDLE;
                default:
                    state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sdram_port_arbiter.sv
// tb_wb_sdram_port_arbiter: scoreboard bench for the SDRAM port arbiter; grant order and
// read responses are queued when stimulus is driven and popped when the DUT produces them.
module tb_wb_sdram_port_arbiter;
    import wb_sdram_arb_pkg::*;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              wb_clk = 1'b0;
    logic              wb_rst_n = 1'b0;
    logic [N*AW-1:0]   wb_adr_i;
    logic [N*DW-1:0]   wb_dat_i;
    logic [N*DW/8-1:0] wb_sel_i;
    logic [N-1:0]      wb_we_i;
    logic [N-1:0]      wb_cyc_i;
    logic [N-1:0]      wb_stb_i;
    logic [N*3-1:0]    wb_cti_i;
    logic [N*2-1:0]    wb_bte_i;
    logic [N*DW-1:0]   wb_dat_o;
    logic [N-1:0]      wb_ack_o;
    logic [AW-1:0]     m_adr_o;
    logic [DW-1:0]     m_dat_o;
    logic [DW/8-1:0]   m_sel_o;
    logic              m_we_o;
    logic              m_cyc_o;
    logic              m_stb_o;
    logic [2:0]        m_cti_o;
    logic [1:0]        m_bte_o;
    logic [DW-1:0]     m_dat_i = '0;
    logic              m_ack_i = 1'b0;
    logic [N-1:0]      grant_o;
    logic              busy_o;

    wb_sdram_port_arbiter #(.WB_PORTS(N), .AW(AW), .DW(DW)) dut (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_cti_i (wb_cti_i),
        .wb_bte_i (wb_bte_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .m_adr_o  (m_adr_o),
        .m_dat_o  (m_dat_o),
        .m_sel_o  (m_sel_o),
        .m_we_o   (m_we_o),
        .m_cyc_o  (m_cyc_o),
        .m_stb_o  (m_stb_o),
        .m_cti_o  (m_cti_o),
        .m_bte_o  (m_bte_o),
        .m_dat_i  (m_dat_i),
        .m_ack_i  (m_ack_i),
        .grant_o  (grant_o),
        .busy_o   (busy_o)
    );

    always #5 wb_clk = ~wb_clk;

    typedef struct packed {
        logic [N-1:0]  ack;
        logic [DW-1:0] dat;
    } rsp_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   exp_q[$];
    rsp_t rsp_q[$];
    bit   up[N];
    int   beat[N];
    int   left[N];
    int   beats_per_burst = 8;

    function automatic logic [AW-1:0] exp_adr(input int p, input int b);
        return AW'((p + 1) * 'h1000 + b * 4);
    endfunction

    function automatic logic [2:0] exp_cti(input int b);
        return (b == beats_per_burst - 1) ? CTI_EOB : 3'b010;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            wb_cyc_i[i]             = up[i];
            wb_stb_i[i]             = up[i];
            wb_we_i[i]              = 1'(i & 1);
            wb_adr_i[i*AW +: AW]    = exp_adr(i, beat[i]);
            wb_dat_i[i*DW +: DW]    = ~exp_adr(i, beat[i]);
            wb_sel_i[i*4 +: 4]      = 4'(i + 1);
            wb_cti_i[i*3 +: 3]      = exp_cti(beat[i]);
            wb_bte_i[i*2 +: 2]      = 2'(i);
        end
    endtask

    task automatic do_reset();
        wb_rst_n = 1'b0;
        m_ack_i  = 1'b0;
        m_dat_i  = '0;
        for (int i = 0; i < N; i++) begin
            up[i]   = 1'b0;
            beat[i] = 0;
            left[i] = 0;
        end
        drive();
        repeat (2) @(negedge wb_clk);
        wb_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        beats_per_burst = 8;
        wb_rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            up[i]   = 1'b1;
            beat[i] = 0;
        end
        drive();
        m_ack_i = 1'b1;
        repeat (3) @(negedge wb_clk);
        vectors++;
        if (grant_o !== '0 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_grant: grant=%b busy=%b, exp grant=000 busy=0", grant_o, busy_o);
        end
        vectors++;
        if ({m_cyc_o, m_stb_o, m_adr_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_mbus: cyc=%b stb=%b adr=%h, exp all 0", m_cyc_o, m_stb_o, m_adr_o);
        end
        vectors++;
        if (wb_ack_o !== '0) begin
            miscompares++;
            $display("FAIL reset_ack: got %b exp 000", wb_ack_o);
        end
        m_ack_i  = 1'b0;
        wb_rst_n = 1'b1;
        @(negedge wb_clk);
        vectors++;
        if (grant_o !== 3'b001 || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_grant: grant=%b busy=%b, exp grant=001 busy=1", grant_o, busy_o);
        end
        vectors++;
        if (m_cyc_o !== 1'b1 || m_adr_o !== exp_adr(0, 0)) begin
            miscompares++;
            $display("FAIL reset_first_mbus: cyc=%b adr=%h, exp cyc=1 adr=%h", m_cyc_o, m_adr_o, exp_adr(0, 0));
        end
        #2 wb_rst_n = 1'b0;
        #1;
        vectors++;
        if (grant_o !== '0 || m_cyc_o !== 1'b0 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: grant=%b cyc=%b busy=%b, exp 000/0/0", grant_o, m_cyc_o, busy_o);
        end
    endtask

    task automatic test_ack_routing();
        rsp_t r;
        do_reset();
        wb_cyc_i           = 3'b010;
        wb_stb_i           = 3'b010;
        wb_we_i            = '0;
        wb_adr_i[AW +: AW] = 32'h1000;
        wb_cti_i[3 +: 3]   = CTI_CLASSIC;
        @(negedge wb_clk);
        vectors++;
        if (grant_o !== 3'b010) begin
            miscompares++;
            $display("FAIL ack_grant_latency: got %b exp 010", grant_o);
        end
        vectors++;
        if ({m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_cti_o} !== {1'b1, 1'b1, 1'b0, 32'h1000, CTI_CLASSIC}) begin
            miscompares++;
            $display("FAIL ack_mbus: cyc=%b stb=%b we=%b adr=%h cti=%b, exp 1 1 0 00001000 000",
                     m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_cti_o);
        end
        m_dat_i = 32'hDEADBEEF;
        m_ack_i = 1'b1;
        rsp_q.push_back('{ack: 3'b010, dat: 32'hDEADBEEF});
        #1;
        r = rsp_q.pop_front();
        vectors++;
        if (wb_ack_o !== r.ack) begin
            miscompares++;
            $display("FAIL ack_route: got %b exp %b", wb_ack_o, r.ack);
        end
        vectors++;
        if (wb_dat_o[DW +: DW] !== r.dat) begin
            miscompares++;
            $display("FAIL ack_data: got %h exp %h", wb_dat_o[DW +: DW], r.dat);
        end
        vectors++;
        if (wb_dat_o[0 +: DW] !== r.dat || wb_dat_o[2*DW +: DW] !== r.dat) begin
            miscompares++;
            $display("FAIL ack_broadcast: got %h exp %h on every slice", wb_dat_o, r.dat);
        end
        @(negedge wb_clk);
        m_ack_i  = 1'b0;
        wb_cyc_i = '0;
        wb_stb_i = '0;
        @(negedge wb_clk);
        vectors++;
        if (grant_o !== '0 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_release: grant=%b busy=%b, exp 000/0", grant_o, busy_o);
        end
    endtask

    task automatic test_stray_ack();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge wb_clk);
            m_ack_i = 1'b1;
            #1;
            vectors++;
            if (wb_ack_o !== '0 || m_cyc_o !== 1'b0) begin
                miscompares++;
                $display("FAIL stray_ack_idle: ack=%b cyc=%b, exp 000/0", wb_ack_o, m_cyc_o);
            end
            m_ack_i = 1'b0;
        end
    endtask

    task automatic test_abort();
        do_reset();
        beats_per_burst = 8;
        up[2] = 1'b1;
        drive();
        @(negedge wb_clk);
        vectors++;
        if (grant_o !== 3'b100) begin
            miscompares++;
            $display("FAIL abort_grant2: got %b exp 100", grant_o);
        end
        up[0] = 1'b1;
        drive();
        for (int k = 0; k < 3; k++) begin
            m_ack_i = 1'b1;
            #1;
            vectors++;
            if (wb_ack_o !== 3'b100) begin
                miscompares++;
                $display("FAIL abort_beat%0d_ack: got %b exp 100", k, wb_ack_o);
            end
            @(negedge wb_clk);
            m_ack_i = 1'b0;
            beat[2]++;
            drive();
        end
        up[2] = 1'b0;
        drive();
        #1;
        vectors++;
        if (grant_o !== 3'b100 || m_cyc_o !== 1'b0 || wb_ack_o !== '0) begin
            miscompares++;
            $display("FAIL abort_drop: grant=%b cyc=%b ack=%b, exp 100/0/000", grant_o, m_cyc_o, wb_ack_o);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge wb_clk);
            m_ack_i = 1'b1;
            #1;
            vectors++;
            if (grant_o !== '0 || m_cyc_o !== 1'b0 || wb_ack_o !== '0) begin
                miscompares++;
                $display("FAIL abort_gap%0d: grant=%b cyc=%b ack=%b, exp 000/0/000", k, grant_o, m_cyc_o, wb_ack_o);
            end
            m_ack_i = 1'b0;
        end
        @(negedge wb_clk);
        vectors++;
        if (grant_o !== 3'b001 || m_cyc_o !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_handoff: grant=%b cyc=%b, exp 001/1", grant_o, m_cyc_o);
        end
        up[0] = 1'b0;
        drive();
        repeat (3) @(negedge wb_clk);
    endtask

    // Burst engine: masters drop cyc after their last ack and re-raise it one cycle later.
    task automatic run_traffic(input int beats, input int q0, input int q1, input int q2, input int budget);
        logic [N-1:0]  acked;
        logic [N-1:0]  prev_grant;
        logic [N-1:0]  exp_ack;
        logic [AW+DW+1+DW/8+3+2-1:0] got_bus;
        logic [AW+DW+1+DW/8+3+2-1:0] exp_bus;
        int got[N];
        int quota[N];
        int cur;
        int idle_run;
        int cyc_cnt;
        int exp_g;
        do_reset();
        beats_per_burst = beats;
        quota[0] = q0;
        quota[1] = q1;
        quota[2] = q2;
        for (int i = 0; i < N; i++) begin
            left[i] = quota[i];
            up[i]   = quota[i] > 0;
            got[i]  = 0;
        end
        drive();
        acked      = '0;
        prev_grant = '0;
        cur        = -1;
        idle_run   = 0;
        cyc_cnt    = 0;
        while (cyc_cnt < budget && (left[0] + left[1] + left[2] > 0 || grant_o != '0)) begin
            @(negedge wb_clk);
            cyc_cnt++;
            if (grant_o != '0 && prev_grant == '0) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL grant_order: got %b, no grant expected", grant_o);
                end else begin
                    exp_g = exp_q.pop_front();
                    if (grant_o !== N'(1 << exp_g)) begin
                        miscompares++;
                        $display("FAIL grant_order: got %b exp %b", grant_o, N'(1 << exp_g));
                    end
                    if (cur >= 0) begin
                        vectors++;
                        if (idle_run != 2) begin
                            miscompares++;
                            $display("FAIL handoff_gap: got %0d idle cycles exp 2", idle_run);
                        end
                    end
                    cur = exp_g;
                end
                for (int i = 0; i < N; i++)
                    if (grant_o[i]) got[i]++;
            end
            idle_run   = (grant_o == '0) ? idle_run + 1 : 0;
            prev_grant = grant_o;
            for (int i = 0; i < N; i++)
                if (acked[i]) begin
                    beat[i]++;
                    if (beat[i] == beats) begin
                        beat[i] = 0;
                        left[i]--;
                        up[i] = 1'b0;
                    end
                end else if (!up[i] && left[i] > 0) begin
                    up[i] = 1'b1;
                end
            drive();
            #1;
            m_dat_i = $urandom;
            m_ack_i = m_cyc_o & m_stb_o;
            #1;
            if (m_cyc_o) begin
                vectors++;
                if (cur < 0) begin
                    miscompares++;
                    $display("FAIL mbus_no_grant: cyc=1 adr=%h before any expected grant", m_adr_o);
                end else begin
                    exp_bus = {exp_adr(cur, beat[cur]), ~exp_adr(cur, beat[cur]), 1'(cur & 1),
                               4'(cur + 1), exp_cti(beat[cur]), 2'(cur)};
                    got_bus = {m_adr_o, m_dat_o, m_we_o, m_sel_o, m_cti_o, m_bte_o};
                    if (got_bus !== exp_bus) begin
                        miscompares++;
                        $display("FAIL mbus_mux: got %h exp %h", got_bus, exp_bus);
                    end
                end
            end
            exp_ack = (m_ack_i && cur >= 0) ? N'(1 << cur) : '0;
            vectors++;
            if (wb_ack_o !== exp_ack) begin
                miscompares++;
                $display("FAIL traffic_ack: got %b exp %b", wb_ack_o, exp_ack);
            end
            if (m_ack_i && cur >= 0) begin
                vectors++;
                if (wb_dat_o[cur*DW +: DW] !== m_dat_i) begin
                    miscompares++;
                    $display("FAIL traffic_rdata: got %h exp %h", wb_dat_o[cur*DW +: DW], m_dat_i);
                end
            end
            acked = wb_ack_o;
        end
        m_ack_i = 1'b0;
        vectors++;
        if (cyc_cnt >= budget) begin
            miscompares++;
            $display("FAIL traffic_timeout: got %0d cycles exp under %0d", cyc_cnt, budget);
        end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (got[i] != quota[i]) begin
                miscompares++;
                $display("FAIL burst_count_port%0d: got %0d exp %0d", i, got[i], quota[i]);
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL grants_missing: got %0d left in queue exp 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_single_requester();
        repeat (3) exp_q.push_back(1);
        run_traffic(2, 0, 3, 0, 500);
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 10; k++)
            for (int p = 0; p < N; p++)
                exp_q.push_back(p);
        run_traffic(8, 10, 10, 10, 2000);
    endtask

    task automatic test_prio();
        repeat (3) exp_q.push_back(0);
        repeat (2) begin
            exp_q.push_back(1);
            exp_q.push_back(2);
        end
        run_traffic(2, 3, 2, 2, 1000);
    endtask

    initial begin
        test_reset();
        test_ack_routing();
        test_stray_ack();
        test_abort();
        test_single_requester();
`ifdef WB_ARB_PORT0_PRIO_EN
        test_prio();
`else
        test_round_robin();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
